// File: rtl/mux_arb_reg_pkg.sv
// Shared definitions for the registered N-way selector/arbiter.
package mux_arb_reg_pkg;

    localparam logic MODE_SEL = 1'b0;
    localparam logic MODE_RR  = 1'b1;

    // Index width for n channels, never below 1.
    function automatic int unsigned sel_width(input int unsigned n);
        int unsigned w;
        w = 0;
        while ((1 << w) < n) begin
            w++;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/mux_arb_reg_rr_arbiter.sv
// Combinational round-robin search: first requester after ptr, wrapping modulo N.
module rr_arbiter
    import mux_arb_reg_pkg::*;
#(
    parameter int unsigned N    = 3,
    parameter int unsigned SELW = 2
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    output logic [SELW-1:0] grant,
    output logic            any_grant
);

    int unsigned idx;

    // Walk offsets from farthest to nearest so the nearest requester is written last.
    always_comb begin
        grant     = '0;
        any_grant = 1'b0;
        idx       = 0;
        for (int k = int'(N); k >= 1; k--) begin
            idx = (32'(ptr) + 32'(k)) % N;
            if (req[idx]) begin
                grant     = SELW'(idx);
                any_grant = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_arb_reg.sv
// N-way WIDTH-bit selector with external-select or round-robin grant and a
// registered valid/ready output stage.
module mux_arb_reg
    import mux_arb_reg_pkg::*;
#(
    parameter  int unsigned WIDTH = 16,
    parameter  int unsigned N     = 3,
    localparam int unsigned SELW  = sel_width(N)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic               mode,
    input  logic [SELW-1:0]    sel,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SELW-1:0]    out_chan,
    output logic               sel_err
);

    localparam int unsigned NSEL = 2 ** SELW;

    logic [SELW-1:0] ptr;
    logic [SELW-1:0] rr_grant;
    logic            rr_any;
    logic [SELW-1:0] grant_idx;
    logic            grant_any;
    logic            sel_ok;
    logic            can_load;
    logic            load;
    logic [NSEL-1:0] valid_ext;

    rr_arbiter #(.N(N), .SELW(SELW)) u_rr (
        .req       (in_valid),
        .ptr       (ptr),
        .grant     (rr_grant),
        .any_grant (rr_any)
    );

    // Grant source mux and handshake; valid is widened so any sel value indexes safely.
    always_comb begin
        valid_ext = NSEL'(in_valid);
        sel_ok    = 32'(sel) < N;
        grant_idx = rr_grant;
        grant_any = rr_any;
        if (mode == MODE_SEL) begin
            grant_idx = sel;
            grant_any = sel_ok & valid_ext[sel];
        end
        can_load = !out_valid | out_ready;
        load     = !reset & can_load & grant_any;
        in_ready = load ? (N'(1) << grant_idx) : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
            sel_err   <= 1'b0;
            ptr       <= SELW'(N - 1);
        end else begin
            sel_err <= (mode == MODE_SEL) & !sel_ok;
            if (load) begin
                out_valid <= 1'b1;
                out_data  <= in_data[32'(grant_idx)*WIDTH +: WIDTH];
                out_chan  <= grant_idx;
                ptr       <= grant_idx;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
